// File: rtl/chan_trig_receiver.sv
// Master-side receiver for per-channel self-trigger lines: synchronizes async levels,
// forms a windowed coincidence, holds a request until ack, then applies deadtime.
module chan_trig_receiver #(
  parameter int NCHAN    = 5,
  parameter int WINDOW   = 2,
  parameter int DEADTIME = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCHAN-1:0] trig_in,
  input  logic [NCHAN-1:0] chan_en,
  input  logic [2:0]       min_mult,
  input  logic             enable,
  input  logic             trig_ack,
  output logic             trig_req,
  output logic [NCHAN-1:0] trig_mask,
  output logic [31:0]      trig_count,
  output logic [15:0]      lost_count,
  output logic             busy
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    COLLECT  = 4'b0010,
    WAIT_ACK = 4'b0100,
    DEAD     = 4'b1000
  } state_t;

  function automatic logic [7:0] popcount(input logic [NCHAN-1:0] v);
    logic [7:0] sum;
    sum = 8'd0;
    for (int i = 0; i < NCHAN; i++) begin
      sum = sum + {7'd0, v[i]};
    end
    return sum;
  endfunction

  (* ASYNC_REG = "TRUE" *) logic [NCHAN-1:0] sync1_r;
  (* ASYNC_REG = "TRUE" *) logic [NCHAN-1:0] sync2_r;
  logic [NCHAN-1:0] sync2_d_r;

  state_t           state_r;
  logic [NCHAN-1:0] pending_r;
  logic [WW-1:0]    win_cnt_r;
  logic [DW-1:0]    ded_cnt_r;
  logic             trig_req_r;
  logic [NCHAN-1:0] trig_mask_r;
  logic [31:0]      trig_count_r;
  logic [15:0]      lost_count_r;
  logic             busy_r;

  logic [NCHAN-1:0] edges_s;
  logic [NCHAN-1:0] window_mask_s;
  logic [7:0]       min_eff_s;
  logic             coinc_s;
  logic             lost_en_s;
  logic [16:0]      lost_sum_s;
  logic [15:0]      lost_next_s;

  // Two-flop synchronizer plus one delay stage for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r   <= '0;
      sync2_r   <= '0;
      sync2_d_r <= '0;
    end else begin
      sync1_r   <= trig_in;
      sync2_r   <= sync1_r;
      sync2_d_r <= sync2_r;
    end
  end

  // Edge qualification, coincidence decision and saturating lost-edge sum
  always_comb begin
    edges_s       = sync2_r & ~sync2_d_r & chan_en;
    window_mask_s = pending_r | edges_s;
    min_eff_s     = 8'd1;
    if (min_mult != 3'd0) begin
      min_eff_s = {5'd0, min_mult};
    end else begin
      min_eff_s = 8'd1;
    end
    coinc_s    = (popcount(window_mask_s) >= min_eff_s);
    lost_en_s  = ((state_r == WAIT_ACK) || (state_r == DEAD)) && (edges_s != '0);
    lost_sum_s = {1'b0, lost_count_r} + {9'd0, popcount(edges_s)};
    if (lost_sum_s[16]) begin
      lost_next_s = 16'hFFFF;
    end else begin
      lost_next_s = lost_sum_s[15:0];
    end
  end

  // Trigger FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      pending_r    <= '0;
      win_cnt_r    <= '0;
      ded_cnt_r    <= '0;
      trig_req_r   <= 1'b0;
      trig_mask_r  <= '0;
      trig_count_r <= 32'd0;
      lost_count_r <= 16'd0;
      busy_r       <= 1'b0;
    end else begin
      if (lost_en_s) begin
        lost_count_r <= lost_next_s;
      end
      case (state_r)
        IDLE: begin
          if (enable && (edges_s != '0)) begin
            state_r   <= COLLECT;
            pending_r <= edges_s;
            win_cnt_r <= WW'(WINDOW - 1);
            busy_r    <= 1'b1;
          end
        end
        COLLECT: begin
          if (!enable) begin
            state_r   <= IDLE;
            pending_r <= '0;
            busy_r    <= 1'b0;
          end else if (win_cnt_r == '0) begin
            pending_r <= '0;
            if (coinc_s) begin
              state_r      <= WAIT_ACK;
              trig_mask_r  <= window_mask_s;
              trig_req_r   <= 1'b1;
              trig_count_r <= trig_count_r + 32'd1;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            pending_r <= window_mask_s;
            win_cnt_r <= win_cnt_r - WW'(1);
          end
        end
        // The handshake always completes, regardless of enable
        WAIT_ACK: begin
          if (trig_ack) begin
            state_r     <= DEAD;
            trig_req_r  <= 1'b0;
            trig_mask_r <= '0;
            ded_cnt_r   <= DW'(DEADTIME - 1);
          end
        end
        DEAD: begin
          if (!enable || (ded_cnt_r == '0)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            ded_cnt_r <= ded_cnt_r - DW'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          pending_r   <= '0;
          trig_req_r  <= 1'b0;
          trig_mask_r <= '0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign trig_req   = trig_req_r;
  assign trig_mask  = trig_mask_r;
  assign trig_count = trig_count_r;
  assign lost_count = lost_count_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_chan_trig_receiver.sv
// Directed bench for chan_trig_receiver: table of single-burst vectors plus
// hand-written sequences for window, hold, deadtime, enable, reset and wrap corners.
`timescale 1ns/1ps
module tb_chan_trig_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  trig_in;
  logic [4:0]  chan_en;
  logic [2:0]  min_mult;
  logic        enable;
  logic        trig_ack;
  logic        trig_req;
  logic [4:0]  trig_mask;
  logic [31:0] trig_count;
  logic [15:0] lost_count;
  logic        busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] cnt_exp;
  logic [15:0] lost_exp;

  chan_trig_receiver #(.NCHAN(5), .WINDOW(2), .DEADTIME(8)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .chan_en(chan_en),
    .min_mult(min_mult), .enable(enable), .trig_ack(trig_ack),
    .trig_req(trig_req), .trig_mask(trig_mask), .trig_count(trig_count),
    .lost_count(lost_count), .busy(busy)
  );

  always #12.5 clk = ~clk;

  typedef struct {
    logic [4:0] en;
    logic [2:0] mm;
    logic [4:0] pulse;
    logic       exp_busy;
    logic       exp_req;
    logic [4:0] exp_mask;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_and_drain();
    @(negedge clk);
    trig_ack = 1'b1;
    cyc(1);
    trig_ack = 1'b0;
    cyc(10);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{5'b11111, 3'd1, 5'b00100, 1'b1, 1'b1, 5'b00100};
    vecs[1] = '{5'b11111, 3'd3, 5'b00011, 1'b1, 1'b0, 5'b00000};
    vecs[2] = '{5'b11111, 3'd3, 5'b10101, 1'b1, 1'b1, 5'b10101};
    vecs[3] = '{5'b11110, 3'd1, 5'b00001, 1'b0, 1'b0, 5'b00000};
    vecs[4] = '{5'b11111, 3'd0, 5'b00010, 1'b1, 1'b1, 5'b00010};
    vecs[5] = '{5'b01111, 3'd2, 5'b10001, 1'b1, 1'b0, 5'b00000};
    vecs[6] = '{5'b11111, 3'd5, 5'b11111, 1'b1, 1'b1, 5'b11111};
    vecs[7] = '{5'b11111, 3'd6, 5'b11111, 1'b1, 1'b0, 5'b00000};
    vecs[8] = '{5'b11011, 3'd2, 5'b01110, 1'b1, 1'b1, 5'b01010};

    rst = 1'b1; trig_in = 5'b0; chan_en = 5'b11111; min_mult = 3'd1;
    enable = 1'b1; trig_ack = 1'b0;
    cnt_exp = 32'd0; lost_exp = 16'd0;
    cyc(3);
    chk("rst_req", {31'd0, trig_req}, 32'd0);
    chk("rst_mask", {27'd0, trig_mask}, 32'd0);
    chk("rst_count", trig_count, 32'd0);
    chk("rst_lost", {16'd0, lost_count}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(2);

    // Table: one simultaneous burst per vector, latency checked at k+3 and k+4
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chan_en = vecs[i].en; min_mult = vecs[i].mm; trig_in = vecs[i].pulse;
      cyc(4);
      chk($sformatf("v%0d_req_early", i), {31'd0, trig_req}, 32'd0);
      chk($sformatf("v%0d_busy_collect", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      cyc(1);
      if (vecs[i].exp_req) cnt_exp = cnt_exp + 32'd1;
      chk($sformatf("v%0d_req", i), {31'd0, trig_req}, {31'd0, vecs[i].exp_req});
      chk($sformatf("v%0d_mask", i), {27'd0, trig_mask}, {27'd0, vecs[i].exp_mask});
      chk($sformatf("v%0d_count", i), trig_count, cnt_exp);
      chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_req});
      trig_in = 5'b0;
      if (vecs[i].exp_req) begin
        @(negedge clk);
        trig_ack = 1'b1;
        cyc(1);
        trig_ack = 1'b0;
        chk($sformatf("v%0d_req_after_ack", i), {31'd0, trig_req}, 32'd0);
        chk($sformatf("v%0d_mask_after_ack", i), {27'd0, trig_mask}, 32'd0);
        cyc(7);
        chk($sformatf("v%0d_busy_dead", i), {31'd0, busy}, 32'd1);
        cyc(1);
        chk($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
      end
      chk($sformatf("v%0d_lost", i), {16'd0, lost_count}, {16'd0, lost_exp});
      cyc(6);
    end
    chan_en = 5'b11111;

    // ch0 then ch3 one cycle later: both inside the window
    min_mult = 3'd2;
    @(negedge clk); trig_in = 5'b00001;
    @(negedge clk); trig_in = 5'b01001;
    cyc(5);
    cnt_exp = cnt_exp + 32'd1;
    chk("win_in_req", {31'd0, trig_req}, 32'd1);
    chk("win_in_mask", {27'd0, trig_mask}, 32'h09);
    chk("win_in_count", trig_count, cnt_exp);
    trig_in = 5'b0;
    ack_and_drain();

    // ch3 three cycles later: window closes first, nothing issued
    @(negedge clk); trig_in = 5'b00001;
    repeat (3) @(negedge clk);
    trig_in = 5'b01001;
    cyc(10);
    chk("win_out_req", {31'd0, trig_req}, 32'd0);
    chk("win_out_count", trig_count, cnt_exp);
    chk("win_out_busy", {31'd0, busy}, 32'd0);
    trig_in = 5'b0;
    cyc(4);

    // Long hold without ack; edges during wait and deadtime are lost
    min_mult = 3'd1;
    @(negedge clk); trig_in = 5'b00100;
    cyc(5);
    cnt_exp = cnt_exp + 32'd1;
    trig_in = 5'b0;
    cyc(5);
    @(negedge clk); trig_in = 5'b00010;
    cyc(5); trig_in = 5'b0;
    chk("hold_mid_req", {31'd0, trig_req}, 32'd1);
    cyc(5);
    @(negedge clk); trig_in = 5'b10000;
    cyc(5); trig_in = 5'b0;
    cyc(20);
    lost_exp = 16'd2;
    chk("hold_req", {31'd0, trig_req}, 32'd1);
    chk("hold_mask", {27'd0, trig_mask}, 32'h04);
    chk("hold_lost", {16'd0, lost_count}, {16'd0, lost_exp});
    @(negedge clk); trig_ack = 1'b1;
    cyc(1);
    trig_ack = 1'b0;
    trig_in = 5'b00010;
    cyc(5); trig_in = 5'b0;
    cyc(6);
    lost_exp = 16'd3;
    chk("dead_lost", {16'd0, lost_count}, {16'd0, lost_exp});
    chk("dead_busy_done", {31'd0, busy}, 32'd0);
    chk("dead_count", trig_count, cnt_exp);

    // enable dropped while collecting
    @(negedge clk); trig_in = 5'b00100;
    cyc(3);
    chk("abort_collect_busy", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    cyc(1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    cyc(4);
    chk("abort_req", {31'd0, trig_req}, 32'd0);
    chk("abort_count", trig_count, cnt_exp);
    trig_in = 5'b0; enable = 1'b1;
    cyc(4);

    // enable dropped while waiting for ack: request is held
    @(negedge clk); trig_in = 5'b10000;
    cyc(5);
    cnt_exp = cnt_exp + 32'd1;
    chk("noabort_req0", {31'd0, trig_req}, 32'd1);
    trig_in = 5'b0; enable = 1'b0;
    cyc(5);
    chk("noabort_req", {31'd0, trig_req}, 32'd1);
    chk("noabort_mask", {27'd0, trig_mask}, 32'h10);
    @(negedge clk); trig_ack = 1'b1;
    cyc(1);
    trig_ack = 1'b0;
    cyc(1);
    chk("noabort_idle", {31'd0, busy}, 32'd0);
    chk("noabort_count", trig_count, cnt_exp);
    enable = 1'b1;
    cyc(4);

    // rst while waiting for ack
    @(negedge clk); trig_in = 5'b01000;
    cyc(5);
    chk("rstmid_req0", {31'd0, trig_req}, 32'd1);
    trig_in = 5'b0;
    @(negedge clk); rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cnt_exp = 32'd0; lost_exp = 16'd0;
    chk("rstmid_req", {31'd0, trig_req}, 32'd0);
    chk("rstmid_mask", {27'd0, trig_mask}, 32'd0);
    chk("rstmid_count", trig_count, cnt_exp);
    chk("rstmid_lost", {16'd0, lost_count}, {16'd0, lost_exp});
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    cyc(4);

    // Counter wrap and lost saturation
    force dut.trig_count_r = 32'hFFFFFFFF;
    force dut.lost_count_r = 16'hFFFE;
    #1;
    release dut.trig_count_r;
    release dut.lost_count_r;
    @(negedge clk); trig_in = 5'b00001;
    cyc(5);
    chk("wrap_req", {31'd0, trig_req}, 32'd1);
    chk("wrap_count", trig_count, 32'd0);
    trig_in = 5'b0;
    cyc(3);
    @(negedge clk); trig_in = 5'b01110;
    cyc(5); trig_in = 5'b0;
    chk("sat_lost", {16'd0, lost_count}, 32'h0000FFFF);
    ack_and_drain();
    chk("sat_lost_hold", {16'd0, lost_count}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
